// File: rtl/memory_ctrl_pkg.sv
// Shared types and helpers for the paged event-memory controller.
package memory_ctrl_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        RD_HOLD  = 2'd3
    } rd_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_page_ring.sv
// Ring bookkeeping: write/read page pointers, committed page count and per-page entry counts.
module mem_page_ring
    import memory_ctrl_pkg::*;
#(
    parameter int NPAGE = 64,
    parameter int PW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  logic [CNT_W-1:0] commit_cnt,
    input  logic             release_page,
    output logic [PW-1:0]    wr_page,
    output logic [PW-1:0]    rd_page,
    output logic [PW:0]      pages_used,
    output logic [CNT_W-1:0] head_cnt
);

    logic [CNT_W-1:0] cnt [NPAGE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_page    <= '0;
            rd_page    <= '0;
            pages_used <= '0;
            for (int i = 0; i < NPAGE; i++) cnt[i] <= '0;
        end else begin
            if (commit) begin
                cnt[wr_page] <= commit_cnt;
                wr_page      <= (wr_page == PW'(NPAGE - 1)) ? '0 : wr_page + PW'(1);
            end
            if (release_page) begin
                rd_page <= (rd_page == PW'(NPAGE - 1)) ? '0 : rd_page + PW'(1);
            end
            // A commit and a release in the same cycle cancel out.
            case ({commit, release_page})
                2'b10:   pages_used <= pages_used + (PW + 1)'(1);
                2'b01:   pages_used <= pages_used - (PW + 1)'(1);
                default: pages_used <= pages_used;
            endcase
        end
    end

    assign head_cnt = cnt[rd_page];

endmodule

// File: rtl/memory_page_ctrl.sv
// Sequences the event BRAM as a ring of fixed-size pages: writes one event per page,
// then replays committed pages in order on a valid/ready stream.
module memory_page_ctrl
    import memory_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH    = 18,
    parameter int RAM_DEPTH    = 1024,
    parameter int PAGE_DEPTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid,
    input  logic [RAM_WIDTH-1:0]            wr_data,
    input  logic                            wr_last,
    output logic                            wr_ready,
    output logic                            rd_valid,
    output logic [RAM_WIDTH-1:0]            rd_data,
    output logic                            rd_last,
    input  logic                            rd_ready,
    output logic [clog2(RAM_DEPTH)-1:0]     mem_addra,
    output logic [RAM_WIDTH-1:0]            mem_dina,
    output logic                            mem_wea,
    output logic [clog2(RAM_DEPTH)-1:0]     mem_addrb,
    output logic                            mem_enb,
    output logic                            mem_regceb,
    output logic                            mem_rstb,
    output logic [4:0]                      mem_nevt,
    input  logic [RAM_WIDTH-1:0]            mem_doutb,
    output logic [clog2(RAM_DEPTH/PAGE_DEPTH):0] pages_used,
    output logic [15:0]                     ovf_count,
    output logic [1:0]                      dbg_state
);

    localparam int AW    = clog2(RAM_DEPTH);
    localparam int NPAGE = RAM_DEPTH / PAGE_DEPTH;
    localparam int PW    = clog2(NPAGE);
    localparam int OW    = clog2(PAGE_DEPTH);

    // Handshakes: a word moves when valid && ready are both high at a rising clk edge;
    // a source holds valid and its payload steady until that edge, ready may change freely.

    logic [OW:0]      wr_off;
    logic             trunc;
    logic             accept;
    logic             wr_fits;
    logic             commit;
    logic             release_page;
    logic [CNT_W-1:0] commit_cnt;
    logic [CNT_W-1:0] head_cnt;
    logic [PW-1:0]    wr_page;
    logic [PW-1:0]    rd_page;
    logic [OW-1:0]    rd_off;
    logic [3:0]       wait_cnt;
    rd_state_t        state;

    mem_page_ring #(
        .NPAGE (NPAGE),
        .PW    (PW)
    ) u_ring (
        .clk          (clk),
        .rst          (rst),
        .commit       (commit),
        .commit_cnt   (commit_cnt),
        .release_page (release_page),
        .wr_page      (wr_page),
        .rd_page      (rd_page),
        .pages_used   (pages_used),
        .head_cnt     (head_cnt)
    );

    assign wr_ready     = (pages_used < (PW + 1)'(NPAGE));
    assign accept       = wr_valid && wr_ready;
    assign wr_fits      = (wr_off < (OW + 1)'(PAGE_DEPTH));
    assign commit       = accept && wr_last;
    assign commit_cnt   = wr_fits ? CNT_W'(wr_off) + CNT_W'(1) : CNT_W'(PAGE_DEPTH);
    assign release_page = (state == RD_HOLD) && rd_ready && rd_last;
    assign mem_nevt     = (pages_used != '0) ? head_cnt : '0;
    assign mem_regceb   = 1'b1;
    assign mem_rstb     = 1'b0;
    assign dbg_state    = state;

    // Write side: words past the page size are dropped and flag the event as truncated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_off    <= '0;
            trunc     <= 1'b0;
            ovf_count <= '0;
            mem_wea   <= 1'b0;
            mem_addra <= '0;
            mem_dina  <= '0;
        end else begin
            mem_wea <= 1'b0;
            if (accept) begin
                if (wr_fits) begin
                    mem_wea   <= 1'b1;
                    mem_addra <= {wr_page, wr_off[OW-1:0]};
                    mem_dina  <= wr_data;
                    wr_off    <= wr_off + (OW + 1)'(1);
                end else begin
                    trunc <= 1'b1;
                end
                if (wr_last) begin
                    wr_off <= '0;
                    trunc  <= 1'b0;
                    if ((trunc || !wr_fits) && ovf_count != 16'hFFFF) begin
                        ovf_count <= ovf_count + 16'd1;
                    end
                end
            end
        end
    end

    // Read FSM: one BRAM read per output word, the word is held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RD_IDLE;
            rd_off    <= '0;
            wait_cnt  <= '0;
            mem_enb   <= 1'b0;
            mem_addrb <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
        end else begin
            mem_enb <= 1'b0;
            case (state)
                RD_IDLE: begin
                    if (pages_used != '0) begin
                        state     <= RD_ISSUE;
                        rd_off    <= '0;
                        mem_enb   <= 1'b1;
                        mem_addrb <= {rd_page, OW'(0)};
                    end
                end
                RD_ISSUE: begin
                    state    <= RD_WAIT;
                    wait_cnt <= '0;
                end
                RD_WAIT: begin
                    if (wait_cnt == 4'(READ_LATENCY - 1)) begin
                        rd_data  <= mem_doutb;
                        rd_last  <= (CNT_W'(rd_off) == head_cnt - CNT_W'(1));
                        rd_valid <= 1'b1;
                        state    <= RD_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        if (rd_last) begin
                            state <= RD_IDLE;
                        end else begin
                            rd_off    <= rd_off + OW'(1);
                            state     <= RD_ISSUE;
                            mem_enb   <= 1'b1;
                            mem_addrb <= {rd_page, rd_off + OW'(1)};
                        end
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_page_ctrl.sv
// Directed bench for memory_page_ctrl with a 2-cycle BRAM model and write/read scoreboards.
module tb_memory_page_ctrl;

    localparam int RW    = 18;
    localparam int DEPTH = 1024;
    localparam int PD    = 16;
    localparam int RL    = 2;
    localparam int AW    = 10;
    localparam int NPAGE = 64;
    localparam int PW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [RW-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          wr_ready;
    logic          rd_valid;
    logic [RW-1:0] rd_data;
    logic          rd_last;
    logic          rd_ready = 1'b0;
    logic [AW-1:0] mem_addra;
    logic [RW-1:0] mem_dina;
    logic          mem_wea;
    logic [AW-1:0] mem_addrb;
    logic          mem_enb;
    logic          mem_regceb;
    logic          mem_rstb;
    logic [4:0]    mem_nevt;
    logic [RW-1:0] mem_doutb;
    logic [PW:0]   pages_used;
    logic [15:0]   ovf_count;
    logic [1:0]    dbg_state;

    memory_page_ctrl #(
        .RAM_WIDTH    (RW),
        .RAM_DEPTH    (DEPTH),
        .PAGE_DEPTH   (PD),
        .READ_LATENCY (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .rd_ready   (rd_ready),
        .mem_addra  (mem_addra),
        .mem_dina   (mem_dina),
        .mem_wea    (mem_wea),
        .mem_addrb  (mem_addrb),
        .mem_enb    (mem_enb),
        .mem_regceb (mem_regceb),
        .mem_rstb   (mem_rstb),
        .mem_nevt   (mem_nevt),
        .mem_doutb  (mem_doutb),
        .pages_used (pages_used),
        .ovf_count  (ovf_count),
        .dbg_state  (dbg_state)
    );

    // clock / BRAM model (HIGH_PERFORMANCE: address register plus output register)
    always #5 clk = ~clk;

    logic [RW-1:0] ram [DEPTH];
    logic [RW-1:0] ram_s1 = '0;
    logic [RW-1:0] ram_s2 = '0;
    always @(posedge clk) begin
        if (mem_wea) ram[mem_addra] <= mem_dina;
        if (mem_enb) ram_s1 <= ram[mem_addrb];
        if (mem_regceb) ram_s2 <= ram_s1;
    end
    assign mem_doutb = ram_s2;

    // scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    logic [AW+RW-1:0] exp_wr_q[$];
    logic [RW:0]      exp_rd_q[$];
    logic [RW-1:0]    pend_q[$];
    int tb_page = 0;
    int tb_off  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitors
    always @(negedge clk) begin
        if (!rst && mem_wea) begin
            if (exp_wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: got 0x%0h expected none", {mem_addra, mem_dina});
            end else begin
                check("mem_write", 32'({mem_addra, mem_dina}), 32'(exp_wr_q[0]));
                void'(exp_wr_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            check("enb_during_hold", 32'(mem_enb), 32'd0);
            if (exp_rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got 0x%0h expected none", {rd_last, rd_data});
            end else begin
                check("rd_word", 32'({rd_last, rd_data}), 32'(exp_rd_q[0]));
                if (rd_ready) void'(exp_rd_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic send_word(input logic [RW-1:0] d, input bit last, input bit with_ready);
        int guard;
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        if (with_ready) rd_ready = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!wr_ready && guard < 2000) begin
            guard++;
            @(negedge clk);
        end
        if (!wr_ready) check("wr_ready_timeout", 32'd0, 32'd1);
        if (tb_off < PD) begin
            exp_wr_q.push_back({AW'(tb_page * PD + tb_off), d});
            pend_q.push_back(d);
        end
        tb_off++;
        if (last) begin
            for (int i = 0; i < pend_q.size(); i++) begin
                exp_rd_q.push_back({(i == pend_q.size() - 1), pend_q[i]});
            end
            pend_q.delete();
            tb_page = (tb_page + 1) % NPAGE;
            tb_off  = 0;
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        if (with_ready) rd_ready = 1'b0;
    endtask

    task automatic send_event(input int n, input logic [RW-1:0] base, input logic [RW-1:0] step);
        for (int i = 0; i < n; i++) begin
            send_word(base + RW'(i) * step, (i == n - 1), 1'b0);
        end
    endtask

    task automatic wait_rd_valid(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rd_valid && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        check(name, 32'(rd_valid), 32'd1);
    endtask

    task automatic drain(input string name, input bit random_ready);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        rd_ready = 1'b1;
        while ((pages_used != '0 || exp_rd_q.size() != 0) && guard < 5000) begin
            @(posedge clk); #1;
            rd_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            guard++;
        end
        rd_ready = 1'b0;
        check({name, "_pages_used"}, 32'(pages_used), 32'd0);
        check({name, "_rd_q_empty"}, 32'(exp_rd_q.size()), 32'd0);
        check({name, "_wr_q_empty"}, 32'(exp_wr_q.size()), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_wr_ready",   32'(wr_ready),   32'd1);
        check("rst_rd_valid",   32'(rd_valid),   32'd0);
        check("rst_rd_last",    32'(rd_last),    32'd0);
        check("rst_rd_data",    32'(rd_data),    32'd0);
        check("rst_mem_wea",    32'(mem_wea),    32'd0);
        check("rst_mem_enb",    32'(mem_enb),    32'd0);
        check("rst_mem_addra",  32'(mem_addra),  32'd0);
        check("rst_mem_addrb",  32'(mem_addrb),  32'd0);
        check("rst_mem_dina",   32'(mem_dina),   32'd0);
        check("rst_mem_nevt",   32'(mem_nevt),   32'd0);
        check("rst_pages_used", 32'(pages_used), 32'd0);
        check("rst_ovf_count",  32'(ovf_count),  32'd0);
        check("rst_state",      32'(dbg_state),  32'd0);
        check("rst_regceb",     32'(mem_regceb), 32'd1);
        check("rst_rstb",       32'(mem_rstb),   32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        rd_ready = 1'b0;
        exp_wr_q.delete();
        exp_rd_q.delete();
        pend_q.delete();
        tb_page = 0;
        tb_off  = 0;
        @(negedge clk);
        check_reset_values();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    // main sequence
    initial begin
        int lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1 rst = 1'b0;

        // single 3-word event, readout stalled until counts are checked
        send_event(3, 18'h00011, 18'h00011);
        lat = 0;
        @(negedge clk);
        check("single_pages_used", 32'(pages_used), 32'd1);
        check("single_nevt", 32'(mem_nevt), 32'd3);
        while (!rd_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check("first_word_latency", 32'(lat), 32'd4);
        drain("single", 1'b0);

        // 20-word event truncates to 16
        send_event(20, 18'h00100, 18'h00001);
        @(negedge clk);
        check("trunc_ovf_count", 32'(ovf_count), 32'd1);
        check("trunc_nevt", 32'(mem_nevt), 32'd16);
        check("trunc_pages_used", 32'(pages_used), 32'd1);
        drain("trunc", 1'b0);

        // exactly 16 words is not a truncation; random backpressure on readout
        send_event(16, 18'h00150, 18'h00001);
        @(negedge clk);
        check("full_page_ovf", 32'(ovf_count), 32'd1);
        check("full_page_nevt", 32'(mem_nevt), 32'd16);
        drain("backpressure", 1'b1);

        // fill all pages, release one, wrap to address 0
        do_reset();
        for (int i = 0; i < NPAGE; i++) send_event(1, 18'h00200 + RW'(i), 18'h0);
        @(negedge clk);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_pages_used", 32'(pages_used), 32'd64);
        @(posedge clk); #1 rd_ready = 1'b1;
        @(posedge clk); #1 rd_ready = 1'b0;
        @(negedge clk);
        check("release_wr_ready", 32'(wr_ready), 32'd1);
        check("release_pages_used", 32'(pages_used), 32'd63);
        send_event(1, 18'h002FF, 18'h0);
        @(negedge clk);
        check("wrap_wea", 32'(mem_wea), 32'd1);
        check("wrap_addra", 32'(mem_addra), 32'd0);
        drain("wrap", 1'b0);

        // commit of a 3-word event in the same cycle as release of a 1-word page
        send_event(1, 18'h003A0, 18'h0);
        wait_rd_valid("simul_head_valid");
        send_word(18'h003B1, 1'b0, 1'b0);
        send_word(18'h003B2, 1'b0, 1'b0);
        send_word(18'h003B3, 1'b1, 1'b1);
        @(negedge clk);
        check("simul_pages_used", 32'(pages_used), 32'd1);
        check("simul_nevt", 32'(mem_nevt), 32'd3);
        drain("simul", 1'b0);

        // reset while a word is held, then a fresh event lands at page 0
        send_event(4, 18'h003C0, 18'h00001);
        wait_rd_valid("midreset_hold");
        do_reset();
        send_event(1, 18'h003AA, 18'h0);
        @(negedge clk);
        check("post_reset_addra", 32'(mem_addra), 32'd0);
        check("post_reset_nevt", 32'(mem_nevt), 32'd1);
        drain("post_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_page_ctrl.md
# memory_page_ctrl

Single-clock controller that sequences the dual-port event BRAM (`Memory`) as a ring of fixed-size pages, one page per event. It accepts a hit stream and writes each event into the next free page, counting the entries it stores. It then replays committed pages in order on a valid/ready output stream and drives the BRAM's read-enable, address and per-page entry count (`nevt`). It sits between the hit-formatting stage and the readout link, with both `Memory` clocks tied to `clk`.

## Interface

Parameters:
- `RAM_WIDTH`, 18, data width; must match `Memory`.
- `RAM_DEPTH`, 1024, BRAM entries; must match `Memory`.
- `PAGE_DEPTH`, 16, entries per page; power of two, ≤16 so that a count fits in 5 bits.
- `READ_LATENCY`, 2, BRAM read latency: 1 for LOW_LATENCY, 2 for HIGH_PERFORMANCE.
- Derived: `AW`=clog2(RAM_DEPTH), `NPAGE`=RAM_DEPTH/PAGE_DEPTH, `PW`=clog2(NPAGE), `OW`=clog2(PAGE_DEPTH).

Ports:
- `clk`  in  1  single clock; also drives `Memory` clka/clkb.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  hit word valid.
- `wr_data`  in  RAM_WIDTH  hit word.
- `wr_last`  in  1  final word of the event; qualified by `wr_valid`.
- `wr_ready`  out  1  controller can accept a word.
- `rd_valid`  out  1  output word valid.
- `rd_data`  out  RAM_WIDTH  output word.
- `rd_last`  out  1  final stored word of the page.
- `rd_ready`  in  1  downstream accepts the word.
- `mem_addra`  out  AW  write address, {page, offset}.
- `mem_dina`  out  RAM_WIDTH  write data.
- `mem_wea`  out  1  write enable.
- `mem_addrb`  out  AW  read address.
- `mem_enb`  out  1  read enable.
- `mem_regceb`  out  1  tied to 1.
- `mem_rstb`  out  1  tied to 0.
- `mem_nevt`  out  5  entry count of the head (read) page.
- `mem_doutb`  in  RAM_WIDTH  BRAM read data.
- `pages_used`  out  PW+1  committed, unread pages.
- `ovf_count`  out  16  saturating count of events that were truncated.

## Operation

Write side:
- `wr_ready` = (`pages_used` < NPAGE).
- On accept: if `wr_off` < PAGE_DEPTH, register a write to {`wr_page`, `wr_off`} and increment `wr_off`. Otherwise drop the word and set the sticky `trunc` flag.
- On an accepted word with `wr_last`:
  - store the count min(words, PAGE_DEPTH) into `cnt[wr_page]`;
  - advance `wr_page`, wrapping NPAGE-1 → 0;
  - increment `pages_used`;
  - clear `wr_off`;
  - if the event was truncated (the dropped word may be the last word itself), increment `ovf_count`, saturating at 0xFFFF.
- Every event holds at least one word, because `wr_last` only counts when `wr_valid` is high.

Read FSM (IDLE, ISSUE, WAIT, HOLD):
- IDLE: if `pages_used` > 0, go to ISSUE with `rd_off`=0.
- ISSUE: drive `mem_enb`=1 and `mem_addrb`={`rd_page`, `rd_off`}. Go to WAIT.
- WAIT: stay for READ_LATENCY-1 cycles, then register `mem_doutb` into `rd_data` and go to HOLD.
- HOLD: `rd_valid`=1; `rd_last`=1 when `rd_off` = `cnt[rd_page]`-1. On `rd_ready`:
  - if `rd_last`: release the page (advance `rd_page` with wrap, decrement `pages_used`) and go to IDLE;
  - otherwise increment `rd_off` and go to ISSUE.
- `mem_nevt` = `cnt[rd_page]` when `pages_used` > 0, else 0.

Boundary behaviour:
- Commit and release in the same cycle leave `pages_used` unchanged.
- The write page is never a committed page, so a read and a write never target the same address.
- Reset in mid-operation discards all pages and counts, and clears `trunc`.

## Timing

- Reset values: `wr_ready`=1, `rd_valid`=0, `rd_last`=0, `rd_data`=0, `mem_wea`=0, `mem_enb`=0, both addresses 0, `mem_dina`=0, `mem_nevt`=0, `pages_used`=0, `ovf_count`=0, FSM in IDLE, all pointers 0.
- Write latency: a word accepted in cycle t produces `mem_wea`/`mem_addra`/`mem_dina` in cycle t+1.
- Commit latency: for a last word accepted in cycle t, `pages_used` increments in t+1.
- First-word latency: IDLE sees `pages_used`>0 in cycle t → ISSUE in t+1 → `rd_valid` in t+2+READ_LATENCY.
- Word-to-word latency: a handshake in cycle t → next `rd_valid` in t+2+READ_LATENCY.
- `rd_data` and `rd_last` are stable while `rd_valid` && !`rd_ready`.
- `wr_ready` drops in the cycle after the NPAGE-th commit. It rises in the cycle after a release.

## Structure

- Package `memory_ctrl_pkg` holds the `clog2` function, the read-FSM state enum, and the count width constant (5).
- Natural sub-module: `mem_page_ring`. It holds the page pointers, `pages_used`, and the `cnt[]` register array with commit/release ports. The top level keeps the write-offset logic and the read FSM.

## Test plan

- Single event: one 3-word event 0x00011, 0x00022, 0x00033 → writes to addresses 0–2; `pages_used`=1, `mem_nevt`=3; readout returns the same three words with `rd_last` on 0x00033; `pages_used` returns to 0.
- Truncation: a 20-word event → 16 writes; `ovf_count`=1; readout gives 16 words with `rd_last` on the 16th.
- Full and wrap: hold `rd_ready` low and commit 64 one-word events → `wr_ready`=0 after the 64th commit. Read one page → `wr_ready`=1 the next cycle; the 65th event writes address 0.
- Backpressure: toggle `rd_ready` randomly over a 16-word page → all words arrive in order, stable while stalled, and no `mem_enb` is issued during HOLD.
- Simultaneous commit and release: align a last-word accept with the final `rd_ready` → `pages_used` stays unchanged and both pointers advance.
- Reset during readout: assert `rst` in HOLD → all outputs return to reset values; a new event then lands at page 0.
